// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the line/frame total and sync-region bound helpers.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    function automatic int rasterTotal(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int syncFirst(int active, int fp);
        return active + fp;
    endfunction

    function automatic int syncLast(int active, int fp, int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/pixel_enable_div.sv
// Divides clkIn down to a one-cycle pixel strobe; 'advance' is the combinational
// qualifier the raster counters use on the same edge the strobe is registered.
module pixel_enable_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clkIn,
    input  logic resetN,
    input  logic enable,
    output logic pixelEn,
    output logic advance
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCnt;

    assign advance = enable && (divCnt == DIV_LAST);

    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            divCnt  <= '0;
            pixelEn <= 1'b0;
        end else begin
            pixelEn <= advance;
            if (advance) begin
                divCnt <= '0;
            end else if (enable) begin
                divCnt <= divCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing on the system clock with a derived pixel enable.
// Optional 8-bit frame counter port when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = DEF_CW
) (
    input  logic          clkIn,
    input  logic          resetN,
    input  logic          enable,
    output logic          pixelEn,
    output logic          hsync,
    output logic          vsync,
    output logic          videoOn,
    output logic [CW-1:0] pixelX,
    output logic [CW-1:0] pixelY,
    output logic          lineStart,
    output logic          frameStart
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]    frameCount
`endif
);

    localparam logic [CW-1:0] H_LAST   = CW'(rasterTotal(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(rasterTotal(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(syncFirst(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] HS_LAST  = CW'(syncLast(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] VS_FIRST = CW'(syncFirst(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] VS_LAST  = CW'(syncLast(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);

    logic          advance;
    logic [CW-1:0] hCnt;
    logic [CW-1:0] vCnt;
    logic [CW-1:0] hNext;
    logic [CW-1:0] vNext;

    pixel_enable_div #(.CLK_DIV(CLK_DIV)) uDiv (
        .clkIn   (clkIn),
        .resetN  (resetN),
        .enable  (enable),
        .pixelEn (pixelEn),
        .advance (advance)
    );

    always_comb begin
        hNext = hCnt + 1'b1;
        vNext = vCnt;
        if (hCnt == H_LAST) begin
            hNext = '0;
            vNext = (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end
    end

    // Counters reset to the last raster position so the first advance lands on (0,0).
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            hCnt       <= H_LAST;
            vCnt       <= V_LAST;
            pixelX     <= '0;
            pixelY     <= '0;
            hsync      <= ~HS_POL;
            vsync      <= ~VS_POL;
            videoOn    <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            if (advance) begin
                hCnt       <= hNext;
                vCnt       <= vNext;
                pixelX     <= hNext;
                pixelY     <= vNext;
                hsync      <= (hNext >= HS_FIRST && hNext <= HS_LAST) ? HS_POL : ~HS_POL;
                vsync      <= (vNext >= VS_FIRST && vNext <= VS_LAST) ? VS_POL : ~VS_POL;
                videoOn    <= (hNext < H_VIS) && (vNext < V_VIS);
                lineStart  <= (hNext == '0);
                frameStart <= (hNext == '0) && (vNext == '0);
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            frameCount <= '0;
        end else if (advance && hNext == '0 && vNext == '0) begin
            frameCount <= frameCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations against an arithmetic raster model.
// Frame counter is covered when VGA_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pe;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int d;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    localparam cfg_t CFG_A = '{d:2, ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, hp:1'b0, vp:1'b0};
    localparam cfg_t CFG_B = '{d:1, ha:4, hfp:1, hsw:2, hbp:1, va:2, vfp:1, vsw:1, vbp:1, hp:1'b0, vp:1'b0};
    localparam cfg_t CFG_C = '{d:3, ha:20, hfp:2, hsw:3, hbp:2, va:10, vfp:1, vsw:2, vbp:1, hp:1'b0, vp:1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB, rstC, enA, enB, enC;
    logic peA, hsA, vsA, vidA, lsA, fsA;
    logic peB, hsB, vsB, vidB, lsB, fsB;
    logic peC, hsC, vsC, vidC, lsC, fsC;
    logic [9:0] pxA, pyA, pxB, pyB, pxC, pyC;
    logic [7:0] fcA, fcB, fcC;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    vga_timing_gen dutA (
        .clkIn(clk), .resetN(rstA), .enable(enA), .pixelEn(peA), .hsync(hsA), .vsync(vsA),
        .videoOn(vidA), .pixelX(pxA), .pixelY(pyA), .lineStart(lsA), .frameStart(fsA)
`ifdef VGA_FRAME_CNT_EN
        , .frameCount(fcA)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dutB (
        .clkIn(clk), .resetN(rstB), .enable(enB), .pixelEn(peB), .hsync(hsB), .vsync(vsB),
        .videoOn(vidB), .pixelX(pxB), .pixelY(pyB), .lineStart(lsB), .frameStart(fsB)
`ifdef VGA_FRAME_CNT_EN
        , .frameCount(fcB)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dutC (
        .clkIn(clk), .resetN(rstC), .enable(enC), .pixelEn(peC), .hsync(hsC), .vsync(vsC),
        .videoOn(vidC), .pixelX(pxC), .pixelY(pyC), .lineStart(lsC), .frameStart(fsC)
`ifdef VGA_FRAME_CNT_EN
        , .frameCount(fcC)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fcA = '0;
    assign fcB = '0;
    assign fcC = '0;
`endif

    // Model: n counts enabled edges since reset; the raster position is simply
    // the number of completed pixel periods folded onto the frame.
    int nA = 0, nB = 0, nC = 0;
    bit stA = 0, stB = 0, stC = 0;

    always @(posedge clk) begin
        if (!rstA) begin nA = 0; stA = 0; end
        else if (enA) begin nA++; stA = (nA % CFG_A.d) == 0; end
        else stA = 0;
        if (!rstB) begin nB = 0; stB = 0; end
        else if (enB) begin nB++; stB = (nB % CFG_B.d) == 0; end
        else stB = 0;
        if (!rstC) begin nC = 0; stC = 0; end
        else if (enC) begin nC++; stC = (nC % CFG_C.d) == 0; end
        else stC = 0;
    end

    always @(negedge rstA) begin nA = 0; stA = 0; end
    always @(negedge rstB) begin nB = 0; stB = 0; end
    always @(negedge rstC) begin nC = 0; stC = 0; end

    function automatic obs_t expectOf(int n, bit st, cfg_t c);
        obs_t e;
        int p, ht, vt, k, x, y;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        p  = n / c.d;
        e    = '0;
        e.hs = ~c.hp;
        e.vs = ~c.vp;
        if (p > 0) begin
            k = (p - 1) % (ht * vt);
            x = k % ht;
            y = k / ht;
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.hs  = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.hp : ~c.hp;
            e.vs  = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.vp : ~c.vp;
            e.vid = (x < c.ha) && (y < c.va);
            e.pe  = st;
            e.ls  = st && (x == 0);
            e.fs  = st && (x == 0) && (y == 0);
`ifdef VGA_FRAME_CNT_EN
            e.fc  = 8'(((p - 1) / (ht * vt) + 1) % 256);
`endif
        end
        return e;
    endfunction

    task automatic checkObs(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkObs("modelA", {peA, hsA, vsA, vidA, lsA, fsA, pxA, pyA, fcA}, expectOf(nA, stA, CFG_A));
        checkObs("modelB", {peB, hsB, vsB, vidB, lsB, fsB, pxB, pyB, fcB}, expectOf(nB, stB, CFG_B));
        checkObs("modelC", {peC, hsC, vsC, vidC, lsC, fsC, pxC, pyC, fcC}, expectOf(nC, stC, CFG_C));
    end

    task automatic testA();
        int t0, per, lows, hsX, vidX;
        bit got;
        per = -1;
        @(negedge clk);
        chk("A edge1 pixelEn", peA, 0);
        chk("A edge1 frameStart", fsA, 0);
        @(negedge clk);
        chk("A edge2 pixelEn", peA, 1);
        chk("A edge2 frameStart", fsA, 1);
        chk("A edge2 lineStart", lsA, 1);
        chk("A edge2 pixelX", pxA, 0);
        chk("A edge2 pixelY", pyA, 0);
        chk("A edge2 videoOn", vidA, 1);
        chk("A edge2 hsync", hsA, 1);
        t0 = cyc;
        @(negedge clk);
        chk("A edge3 pixelEn", peA, 0);
        @(negedge clk);
        chk("A edge4 pixelEn", peA, 1);
        lows = 0; hsX = -1; vidX = -1; got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (!hsA) begin
                if (hsX < 0) hsX = int'(pxA);
                lows++;
            end
            if (!vidA && vidX < 0) vidX = int'(pxA);
            if (lsA) begin
                got = 1;
                per = cyc - t0;
            end
        end
        chk("A lineStart seen", got, 1);
        chk("A lineStart period", per, 1600);
        chk("A hsync low cycles", lows, 192);
        chk("A hsync start pixelX", hsX, 656);
        chk("A videoOn off pixelX", vidX, 640);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (pxA == 10'd300 && pyA == 10'd1) got = 1;
        end
        chk("A reach 300,1", got, 1);
        #2 rstA = 1'b0;
        #1;
        chk("A rst pixelX", pxA, 0);
        chk("A rst pixelY", pyA, 0);
        chk("A rst hsync", hsA, 1);
        chk("A rst vsync", vsA, 1);
        chk("A rst videoOn", vidA, 0);
        chk("A rst pixelEn", peA, 0);
        @(negedge clk);
        #1 rstA = 1'b1;
        @(negedge clk);
        chk("A post-rst edge1 frameStart", fsA, 0);
        @(negedge clk);
        chk("A post-rst edge2 frameStart", fsA, 1);
        chk("A post-rst edge2 pixelX", pxA, 0);
    endtask

    task automatic testB();
        int peHigh;
        int fsCyc[$];
        peHigh = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (peB) peHigh++;
            if (fsB) fsCyc.push_back(cyc);
            if (i < 40) begin
                chk("B pixelX seq", pxB, i % 8);
                chk("B pixelY seq", pyB, (i / 8) % 5);
                chk("B hsync", hsB, ((i % 8) == 5 || (i % 8) == 6) ? 0 : 1);
                chk("B vsync", vsB, ((i / 8) % 5 == 3) ? 0 : 1);
            end
        end
        chk("B pixelEn high count", peHigh, 120);
        chk("B frameStart count", fsCyc.size(), 3);
        if (fsCyc.size() == 3) begin
            chk("B frameStart period1", fsCyc[1] - fsCyc[0], 40);
            chk("B frameStart period2", fsCyc[2] - fsCyc[1], 40);
        end
    endtask

    task automatic testC();
        int fsN, f0, f1, f2, vsLows, vsY;
        bit got;
        fsN = 0; f0 = 0; f1 = 0; f2 = 0; vsLows = 0; vsY = -1;
        for (int i = 0; i < 2500 && fsN < 3; i++) begin
            @(negedge clk);
            if (fsC) begin
                if (fsN == 0) f0 = cyc;
                else if (fsN == 1) f1 = cyc;
                else f2 = cyc;
`ifdef VGA_FRAME_CNT_EN
                chk("C frameCount", fcC, fsN + 1);
`endif
                fsN++;
            end
            if (fsN == 1 && !vsC) begin
                if (vsY < 0) vsY = int'(pyC);
                vsLows++;
            end
        end
        chk("C frameStart count", fsN, 3);
        chk("C frame period1", f1 - f0, 1134);
        chk("C frame period2", f2 - f1, 1134);
        chk("C vsync low cycles", vsLows, 162);
        chk("C vsync start pixelY", vsY, 11);
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (pxC == 10'd10 && peC) got = 1;
        end
        chk("C reach pixelX 10", got, 1);
        @(negedge clk);
        enC = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("C hold pixelEn", peC, 0);
            chk("C hold lineStart", lsC, 0);
            chk("C hold pixelX", pxC, 10);
        end
        enC = 1'b1;
        @(negedge clk);
        chk("C resume1 pixelX", pxC, 10);
        chk("C resume1 pixelEn", peC, 0);
        @(negedge clk);
        chk("C resume2 pixelX", pxC, 11);
        chk("C resume2 pixelEn", peC, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        enA  = 1'b1; enB  = 1'b1; enC  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        fork
            testA();
            testB();
            testC();
        join
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed pixel-clock divider.
- Derives a pixel-rate clock enable from the system clock rather than a generated clock.
- Runs horizontal and vertical raster counters and decodes hsync, vsync, active-video and per-line/per-frame pulses.
- Feeds the Pong renderer and the VGA pins; all logic is on the single system clock.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 10, raster counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clkIn  in  1  system clock; all logic on rising edge
- resetN  in  1  asynchronous active-low reset
- enable  in  1  run; low freezes divider and counters
- pixelEn  out  1  one-clkIn-cycle pixel strobe
- hsync  out  1  horizontal sync at HS_POL when asserted
- vsync  out  1  vertical sync at VS_POL when asserted
- videoOn  out  1  current pixel is visible
- pixelX  out  CW  horizontal counter
- pixelY  out  CW  vertical counter
- lineStart  out  1  pulse when pixelX becomes 0
- frameStart  out  1  pulse when (pixelX,pixelY) becomes (0,0)
- frameCount  out  8  frames since reset (present only with VGA_FRAME_CNT_EN)

Behaviour:
- Definitions:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL analogous
  - HS region: hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VS region analogous on vCnt
- Reset (async, resetN low):
  - divCnt=0; hCnt=H_TOTAL-1; vCnt=V_TOTAL-1
  - pixelEn=0, hsync=~HS_POL, vsync=~VS_POL, videoOn=0, pixelX=0, pixelY=0, lineStart=0, frameStart=0
- Divider:
  - When enable: divCnt increments and wraps at CLK_DIV-1.
  - pixelEn is registered high for exactly one cycle, on the edge where divCnt wraps.
  - CLK_DIV=1: pixelEn high every cycle while enabled.
- Advance (on a cycle where divCnt wraps):
  - hCnt wraps H_TOTAL-1→0; otherwise increments.
  - vCnt increments only on hCnt wrap; wraps V_TOTAL-1→0.
  - First advance after reset therefore lands on (0,0).
- Outputs:
  - All registered; updated on the same edge the counters advance, decoded from the new counter values.
  - hsync/vsync = POL inside their region, else ~POL.
  - videoOn = hCnt<H_ACTIVE && vCnt<V_ACTIVE.
  - pixelX=hCnt, pixelY=vCnt.
  - lineStart/frameStart high for that one cycle only, otherwise 0.
- enable low:
  - divCnt and counters hold; pixelEn, lineStart, frameStart forced 0.
  - Sync and videoOn levels hold.
  - Re-enable resumes from held divCnt, with no extra strobe.
- Reset mid-frame: immediate return to the reset values above; the next advance produces frameStart.
- Latency from reset release with enable high: first pixelEn and frameStart on clkIn edge CLK_DIV.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- With it: frameCount port exists, resets to 0, increments on every frameStart, wraps 255→0.
- Without it: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants
  - H_TOTAL/V_TOTAL derivation
  - sync-region bound localparams
- One sub-module, pixel_enable_div: parametrised CLK_DIV counter producing the pixelEn strobe and the advance qualifier.

Test Plan:
- Defaults, reset release with enable=1:
  - pixelEn first at edge 2, then every 2 cycles.
  - frameStart and lineStart at edge 2 with pixelX=0, pixelY=0, videoOn=1.
- Defaults, free-run one line:
  - hsync low for exactly 192 clkIn cycles, starting when pixelX=656.
  - videoOn low from pixelX=640.
  - lineStart period 1600 cycles.
- Defaults, free-run one frame:
  - vsync low for 2 lines (pixelY 490–491).
  - frameStart period 840000 cycles.
  - With VGA_FRAME_CNT_EN, frameCount=1 then 2.
- CLK_DIV=1, H 4/1/2/1, V 2/1/1/1:
  - pixelEn constantly high.
  - hCnt sequence 0..7, hsync active at 5–6; V_TOTAL=5.
  - frameStart every 40 cycles.
- enable dropped for 10 cycles at pixelX=100:
  - pixelEn/lineStart stay 0 and counters hold.
  - After re-enable, the next pixelX is 101, after the remaining divider count.
- resetN pulsed low asynchronously mid-line (pixelX=300, pixelY=200):
  - Outputs take reset values immediately.
  - frameStart appears CLK_DIV cycles after release.
